pulse_meter: RTL and testbench
==============================

PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter W, default 32: width of the measured count and of the timeout limit.
REQ-002 Parameter N_PER, default 1, legal 1..255: number of consecutive intervals accumulated per measurement.
REQ-003 Parameter SYNC, default 2, legal >=2: number of synchronizer flops on wave.
REQ-004 Port clk  in  1: clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 Port wave  in  1: asynchronous signal under measurement.
REQ-007 Port start  in  1: measurement request, level-sampled.
REQ-008 Port abort  in  1: cancels any measurement in progress.
REQ-009 Port mode  in  2: 00 high time; 01 low time; 10 and 11 period.
REQ-010 Port timeout  in  W: timeout limit in clk cycles; 0 disables the timeout.
REQ-011 Port busy  out  1: high while a measurement is in progress.
REQ-012 Port done  out  1: one-cycle pulse when a result is valid.
REQ-013 Port val  out  W: measured cycle count.
REQ-014 Port ovf  out  1: count saturated during the last measurement.
REQ-015 Port tmo  out  1: last measurement ended by timeout.

Function
REQ-016 wave shall pass through SYNC flops to give ws; ws_d is ws delayed one cycle; rise = ws & ~ws_d; fall = ~ws & ws_d; the edge registers shall update every cycle regardless of state.
REQ-017 The state machine shall have states IDLE, ARM and MEAS, with busy = (state != IDLE), decoded combinationally.
REQ-018 In IDLE, start=1 shall be accepted: mode and timeout are latched; val, ovf and tmo are cleared; the timer and the edge counter are cleared; state goes to ARM.
REQ-019 The starting edge shall be rise for modes 00, 10 and 11, and fall for mode 01; the terminating edge shall be fall for 00, rise for 01, and rise for 10 and 11.
REQ-020 In ARM, a starting edge shall set val to 1 and move the state to MEAS; start shall be ignored outside IDLE.
REQ-021 In MEAS, mode 00 shall increment val on each cycle with ws=1, and mode 01 on each cycle with ws=0.
REQ-022 In MEAS, modes 10 and 11 shall increment val every cycle except the cycle of the final terminating edge.
REQ-023 Each terminating edge in MEAS shall increment the 8-bit edge counter; when the count reaches N_PER the state shall return to IDLE and done shall pulse on the following cycle.
REQ-024 Expected results: a single high pulse of H cycles in mode 00 gives val=H; N_PER periods of P cycles in mode 10 give val=N_PER*P.
REQ-025 val shall saturate at 2^W-1 instead of wrapping; any increment attempted at saturation shall set ovf, and the measurement shall continue.
REQ-026 The timer shall increment each cycle in ARM or MEAS.
REQ-027 With a nonzero latched timeout, the timer reaching timeout without completion in that cycle shall set tmo, go to IDLE and pulse done; val shall hold the partial count (0 if still in ARM).
REQ-028 If completion and timeout occur in the same cycle, completion shall win and tmo shall stay 0.
REQ-029 abort=1 shall force IDLE from any state without a done pulse, leaving val, ovf and tmo unchanged; abort shall win over start in the same cycle.
REQ-030 done shall be a registered single-cycle pulse; val, ovf and tmo shall be stable from the done cycle until the next accepted start.
REQ-031 Latency from a wave transition at the input pins to the corresponding edge detection shall be SYNC cycles.
REQ-032 An accepted start shall give busy=1 on the next cycle; start may be asserted in the done cycle and shall be accepted there.

Reset
REQ-033 rst_n low shall force state IDLE, busy=0, done=0, val=0, ovf=0, tmo=0, and clear the synchronizer flops, ws_d, timer, edge counter and latched mode/timeout.
REQ-034 Reset asserted mid-measurement shall abort immediately with no done pulse; after release, the block shall wait in IDLE for start.

Verification
REQ-035 Mode 00, N_PER=1, wave 10 cycles high / 10 low, start while low -> done pulse, val=10, ovf=0, tmo=0.
REQ-036 Mode 10, N_PER=4, period 7 cycles (3 high / 4 low) -> val=28, exactly one done pulse.
REQ-037 Mode 01, wave low 5 cycles between highs -> val=5; mode 11 on the same stimulus as REQ-036 -> val=28.
REQ-038 W=4, mode 00, high pulse 20 cycles -> val=15, ovf=1.
REQ-039 timeout=50, wave held 0 -> done 50 cycles after ARM entry, tmo=1, val=0; a pulse completing exactly on the timeout cycle -> tmo=0.
REQ-040 Abort in MEAS -> busy=0 next cycle, no done, previous val kept; rst_n pulsed mid-MEAS -> all outputs 0, then a new start measures correctly.

Source files
------------

// File: rtl/pulse_meter_if.sv
// Control/result bundle of the pulse meter: measurement request, abort,
// mode and timeout limit towards the meter; busy/done and the result back.
interface pulse_meter_if #(
  parameter int W = 32
);
  logic         start;
  logic         abort;
  logic [1:0]   mode;
  logic [W-1:0] timeout;
  logic         busy;
  logic         done;
  logic [W-1:0] val;
  logic         ovf;
  logic         tmo;

  modport master (
    output start, abort, mode, timeout,
    input  busy, done, val, ovf, tmo
  );

  modport slave (
    input  start, abort, mode, timeout,
    output busy, done, val, ovf, tmo
  );
endinterface

// File: rtl/pulse_meter.sv
// Pulse meter: measures high time, low time or period of an asynchronous
// input in clk cycles, accumulating N_PER intervals per measurement, with
// saturation, optional timeout and abort.
module pulse_meter #(
  parameter int W     = 32,
  parameter int N_PER = 1,
  parameter int SYNC  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wave,
  pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [7:0]   NPER_C = 8'(N_PER);
  localparam logic [W-1:0] ONE_C  = W'(1);
  localparam logic [W-1:0] MAX_C  = '1;

  logic [SYNC-1:0] sync_r;
  logic            ws_s;
  logic            ws_d_r;
  logic            rise_s;
  logic            fall_s;

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      mode_r;
  logic [1:0]      mode_s;
  logic [W-1:0]    lim_r;
  logic [W-1:0]    lim_s;
  logic [W-1:0]    timer_r;
  logic [W-1:0]    timer_s;
  logic [W-1:0]    val_r;
  logic [W-1:0]    val_s;
  logic [7:0]      ecnt_r;
  logic [7:0]      ecnt_s;
  logic            ovf_r;
  logic            ovf_s;
  logic            tmo_r;
  logic            tmo_s;
  logic            done_r;
  logic            done_s;

  logic            start_edge_s;
  logic            term_edge_s;
  logic            last_s;
  logic            tmo_hit_s;
  logic            inc_s;

  // Synchronizer chain and one-cycle-delayed copy for edge detection; runs every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      ws_d_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC-2:0], wave};
      ws_d_r <= ws_s;
    end
  end

  assign ws_s   = sync_r[SYNC-1];
  assign rise_s = ws_s & ~ws_d_r;
  assign fall_s = ~ws_s & ws_d_r;

  // Decode which edge opens/closes an interval, whether val counts this cycle, and end conditions.
  always_comb begin
    start_edge_s = 1'b0;
    term_edge_s  = 1'b0;
    inc_s        = 1'b0;
    case (mode_r)
      2'b00: begin
        start_edge_s = rise_s;
        term_edge_s  = fall_s;
      end
      2'b01: begin
        start_edge_s = fall_s;
        term_edge_s  = rise_s;
      end
      default: begin
        start_edge_s = rise_s;
        term_edge_s  = rise_s;
      end
    endcase
    // The final closing edge is the one that brings the edge count up to N_PER.
    last_s    = term_edge_s && ((ecnt_r + 8'd1) == NPER_C);
    tmo_hit_s = (lim_r != '0) && ((timer_r + ONE_C) == lim_r);
    case (mode_r)
      2'b00:   inc_s = ws_s;
      2'b01:   inc_s = ~ws_s;
      default: inc_s = ~last_s;
    endcase
  end

  // Next-state and next-result logic of the measurement FSM.
  always_comb begin
    state_s = state_r;
    mode_s  = mode_r;
    lim_s   = lim_r;
    timer_s = timer_r;
    val_s   = val_r;
    ecnt_s  = ecnt_r;
    ovf_s   = ovf_r;
    tmo_s   = tmo_r;
    done_s  = 1'b0;
    if (bus.abort) begin
      // Abort leaves the last results visible and suppresses done.
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mode_s  = bus.mode;
            lim_s   = bus.timeout;
            val_s   = '0;
            ovf_s   = 1'b0;
            tmo_s   = 1'b0;
            timer_s = '0;
            ecnt_s  = 8'd0;
            state_s = ARM;
          end else begin
            state_s = IDLE;
          end
        end
        ARM: begin
          timer_s = timer_r + ONE_C;
          if (tmo_hit_s) begin
            tmo_s   = 1'b1;
            done_s  = 1'b1;
            state_s = IDLE;
          end else if (start_edge_s) begin
            val_s   = ONE_C;
            state_s = MEAS;
          end else begin
            state_s = ARM;
          end
        end
        MEAS: begin
          timer_s = timer_r + ONE_C;
          if (inc_s) begin
            if (val_r == MAX_C) begin
              ovf_s = 1'b1;
            end else begin
              val_s = val_r + ONE_C;
            end
          end else begin
            val_s = val_r;
          end
          if (term_edge_s) begin
            ecnt_s = ecnt_r + 8'd1;
          end else begin
            ecnt_s = ecnt_r;
          end
          // Completion takes priority over a timeout landing in the same cycle.
          if (last_s) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else if (tmo_hit_s) begin
            tmo_s   = 1'b1;
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = MEAS;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state, latched configuration, counters and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      mode_r  <= 2'b00;
      lim_r   <= '0;
      timer_r <= '0;
      val_r   <= '0;
      ecnt_r  <= 8'd0;
      ovf_r   <= 1'b0;
      tmo_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      lim_r   <= lim_s;
      timer_r <= timer_s;
      val_r   <= val_s;
      ecnt_r  <= ecnt_s;
      ovf_r   <= ovf_s;
      tmo_r   <= tmo_s;
      done_r  <= done_s;
    end
  end

  assign bus.busy = (state_r != IDLE);
  assign bus.done = done_r;
  assign bus.val  = val_r;
  assign bus.ovf  = ovf_r;
  assign bus.tmo  = tmo_r;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: three instances (N_PER=1, N_PER=4, W=4) share one
// wave; a vector table plus hand sequences push expected results into a
// scoreboard that is popped whenever an instance pulses done.
module tb_pulse_meter;

  logic clk;
  logic rst_n;
  logic wave;

  pulse_meter_if #(.W(32)) b0 ();
  pulse_meter_if #(.W(32)) b1 ();
  pulse_meter_if #(.W(4))  b2 ();

  pulse_meter #(.W(32), .N_PER(1), .SYNC(2)) dut0 (.clk(clk), .rst_n(rst_n), .wave(wave), .bus(b0));
  pulse_meter #(.W(32), .N_PER(4), .SYNC(2)) dut1 (.clk(clk), .rst_n(rst_n), .wave(wave), .bus(b1));
  pulse_meter #(.W(4),  .N_PER(1), .SYNC(2)) dut2 (.clk(clk), .rst_n(rst_n), .wave(wave), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    int          id;
    logic [31:0] v;
    logic        o;
    logic        t;
  } exp_t;

  typedef struct {
    int          d;
    logic [1:0]  mode;
    int          hi;
    int          lo;
    int          reps;
    logic [31:0] ev;
    logic        eo;
    logic        et;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[11];
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   ndone[3];
  int   last_done[3];

  task automatic check(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s#%0d: actual %0d required %0d", nm, id, act, req);
    end
  endtask

  task automatic push_exp(input int d, input int id, input logic [31:0] v, input logic o, input logic t);
    exp_t e;
    e.d = d; e.id = id; e.v = v; e.o = o; e.t = t;
    sbq.push_back(e);
  endtask

  task automatic mon(input int d, input logic dn, input logic [31:0] v, input logic o, input logic t);
    exp_t e;
    if (dn) begin
      ndone[d]++;
      last_done[d] = cyc;
      if (sbq.size() == 0 || sbq[0].d != d) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: dut%0d actual done=1 required none", d);
      end else begin
        e = sbq.pop_front();
        check(e.id, "val", v, e.v);
        check(e.id, "ovf", {31'd0, o}, {31'd0, e.o});
        check(e.id, "tmo", {31'd0, t}, {31'd0, e.t});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon(0, b0.done, b0.val, b0.ovf, b0.tmo);
    mon(1, b1.done, b1.val, b1.ovf, b1.tmo);
    mon(2, b2.done, {28'd0, b2.val}, b2.ovf, b2.tmo);
  endtask

  function automatic logic [31:0] dbusy(input int d);
    case (d)
      0:       return {31'd0, b0.busy};
      1:       return {31'd0, b1.busy};
      default: return {31'd0, b2.busy};
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       b0.start = v;
      1:       b1.start = v;
      default: b2.start = v;
    endcase
  endtask

  task automatic set_mode(input logic [1:0] m);
    b0.mode = m; b1.mode = m; b2.mode = m;
  endtask

  task automatic wait_empty(input int id, input int budget);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL no_done#%0d: actual none within %0d cycles required done", id, budget);
      sbq.delete();
    end
  endtask

  task automatic run_meas(input int d, input int id, input logic [1:0] m, input int hi, input int lo,
                          input int reps, input logic [31:0] ev, input logic eo, input logic et);
    set_mode(m);
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    check(id, "busy_after_start", dbusy(d), 32'd1);
    push_exp(d, id, ev, eo, et);
    for (int r = 0; r < reps; r++) begin
      wave = 1'b1;
      repeat (hi) tick();
      wave = 1'b0;
      repeat (lo) tick();
    end
    wait_empty(id, 60);
    repeat (6) tick();
  endtask

  initial begin
    int s;
    int k;
    int nd1_exp;
    logic found;

    n_cmp = 0; n_err = 0; cyc = 0; nd1_exp = 0;
    for (int i = 0; i < 3; i++) begin
      ndone[i] = 0;
      last_done[i] = 0;
    end
    //        dut mode   hi  lo reps  val  ovf   tmo
    vt[0]  = '{0, 2'b00, 10, 10, 1, 32'd10, 1'b0, 1'b0};
    vt[1]  = '{1, 2'b10,  3,  4, 5, 32'd28, 1'b0, 1'b0};
    vt[2]  = '{0, 2'b01,  3,  5, 2, 32'd5,  1'b0, 1'b0};
    vt[3]  = '{1, 2'b11,  3,  4, 5, 32'd28, 1'b0, 1'b0};
    vt[4]  = '{2, 2'b00, 20,  5, 1, 32'd15, 1'b1, 1'b0};
    vt[5]  = '{2, 2'b00, 15,  5, 1, 32'd15, 1'b0, 1'b0};
    vt[6]  = '{2, 2'b00, 16,  5, 1, 32'd15, 1'b1, 1'b0};
    vt[7]  = '{0, 2'b00,  1,  4, 1, 32'd1,  1'b0, 1'b0};
    vt[8]  = '{0, 2'b10,  2,  3, 2, 32'd5,  1'b0, 1'b0};
    vt[9]  = '{1, 2'b01,  3,  5, 5, 32'd20, 1'b0, 1'b0};
    vt[10] = '{1, 2'b00,  3,  4, 5, 32'd12, 1'b0, 1'b0};

    rst_n = 1'b0; wave = 1'b0;
    b0.start = 1'b0; b0.abort = 1'b0; b0.mode = 2'b00; b0.timeout = 32'd0;
    b1.start = 1'b0; b1.abort = 1'b0; b1.mode = 2'b00; b1.timeout = 32'd0;
    b2.start = 1'b0; b2.abort = 1'b0; b2.mode = 2'b00; b2.timeout = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check(0, "rst_busy", {31'd0, b0.busy}, 32'd0);
    check(0, "rst_done", {31'd0, b0.done}, 32'd0);
    check(0, "rst_val",  b0.val, 32'd0);
    check(0, "rst_ovf",  {31'd0, b0.ovf}, 32'd0);
    check(0, "rst_tmo",  {31'd0, b0.tmo}, 32'd0);
    check(0, "rst_val_w4", {28'd0, b2.val}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Table-driven measurements
    for (int i = 0; i < 11; i++) begin
      if (vt[i].d == 1) nd1_exp++;
      run_meas(vt[i].d, i, vt[i].mode, vt[i].hi, vt[i].lo, vt[i].reps, vt[i].ev, vt[i].eo, vt[i].et);
    end
    check(1, "done_count_nper4", 32'(ndone[1]), 32'(nd1_exp));

    // Timeout with wave held low: done 50 cycles after entering ARM, val 0
    set_mode(2'b00);
    b0.timeout = 32'd50;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    b0.timeout = 32'd0;
    s = cyc;
    check(20, "busy_after_start", {31'd0, b0.busy}, 32'd1);
    push_exp(0, 20, 32'd0, 1'b0, 1'b1);
    wait_empty(20, 80);
    check(20, "tmo_latency", 32'(last_done[0] - s), 32'd50);
    repeat (4) tick();

    // Pulse whose closing edge lands on the timeout cycle: completion wins
    b0.timeout = 32'd20;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    b0.timeout = 32'd0;
    push_exp(0, 21, 32'd16, 1'b0, 1'b0);
    tick();
    wave = 1'b1;
    repeat (16) tick();
    wave = 1'b0;
    wait_empty(21, 40);
    repeat (6) tick();

    // Abort in MEAS: idle next cycle, partial val kept, no done
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    tick();
    wave = 1'b1;
    repeat (5) tick();
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    check(22, "abort_busy", {31'd0, b0.busy}, 32'd0);
    check(22, "abort_val",  b0.val, 32'd3);
    check(22, "abort_ovf",  {31'd0, b0.ovf}, 32'd0);
    check(22, "abort_tmo",  {31'd0, b0.tmo}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      if (i == 4) wave = 1'b0;
      tick();
      check(22, "abort_no_done", {31'd0, b0.done}, 32'd0);
    end

    // Abort beats start in IDLE
    b0.start = 1'b1;
    b0.abort = 1'b1;
    tick();
    b0.start = 1'b0;
    b0.abort = 1'b0;
    check(23, "abort_vs_start_busy", {31'd0, b0.busy}, 32'd0);
    check(23, "abort_vs_start_val",  b0.val, 32'd3);
    repeat (3) tick();

    // Start accepted in the done cycle
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    push_exp(0, 40, 32'd4, 1'b0, 1'b0);
    tick();
    wave = 1'b1;
    repeat (4) tick();
    wave = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      tick();
      k++;
      if (b0.done) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL no_done#40: actual none within 20 cycles required done");
      sbq.delete();
    end else begin
      b0.start = 1'b1;
      push_exp(0, 41, 32'd7, 1'b0, 1'b0);
      tick();
      b0.start = 1'b0;
      check(41, "busy_after_done_start", {31'd0, b0.busy}, 32'd1);
      check(41, "done_single_cycle", {31'd0, b0.done}, 32'd0);
      tick();
      wave = 1'b1;
      repeat (7) tick();
      wave = 1'b0;
      wait_empty(41, 30);
    end
    repeat (6) tick();

    // Reset mid-measurement on the W=4 instance after it saturated
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    wave = 1'b1;
    repeat (20) tick();
    check(30, "pre_rst_busy", {31'd0, b2.busy}, 32'd1);
    check(30, "pre_rst_ovf",  {31'd0, b2.ovf}, 32'd1);
    rst_n = 1'b0;
    #1;
    check(30, "mid_rst_busy", {31'd0, b2.busy}, 32'd0);
    check(30, "mid_rst_done", {31'd0, b2.done}, 32'd0);
    check(30, "mid_rst_val",  {28'd0, b2.val}, 32'd0);
    check(30, "mid_rst_ovf",  {31'd0, b2.ovf}, 32'd0);
    check(30, "mid_rst_tmo",  {31'd0, b2.tmo}, 32'd0);
    wave = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    check(30, "post_rst_idle", {31'd0, b2.busy}, 32'd0);
    run_meas(2, 31, 2'b00, 6, 6, 1, 32'd6, 1'b0, 1'b0);

    check(99, "scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
